// File: rtl/noc_injector.sv
// Local-core packet injector: buffers one packet, requests a circuit with a HEADER flit,
// then streams BODY/TAIL flits on ack or backs off exponentially on reject.
package noc_injector_pkg;
   localparam int unsigned COORD_W   = 2;
   localparam int unsigned ADDR_W    = 2 * COORD_W;
   localparam int unsigned PAYLOAD_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } addr_t;

   typedef enum logic [1:0] {
      FLIT_NONE   = 2'd0,
      FLIT_HEADER = 2'd1,
      FLIT_BODY   = 2'd2,
      FLIT_TAIL   = 2'd3
   } flit_type_t;

   typedef struct packed {
      addr_t                           dst_addr;
      addr_t                           src_addr;
      logic [PAYLOAD_W-2*ADDR_W-1:0]   rsvd;
   } flit_hdr_t;

   typedef struct packed {
      flit_type_t             flit_type;
      logic [PAYLOAD_W-1:0]   payload;
   } flit_t;

   localparam int unsigned FLIT_W = $bits(flit_t);
endpackage

module noc_injector
   import noc_injector_pkg::*;
#(
   parameter int unsigned X            = 1,
   parameter int unsigned Y            = 1,
   parameter int unsigned MAX_LEN      = 8,
   parameter int unsigned BACKOFF_BASE = 2,
   parameter int unsigned BACKOFF_MAX  = 16,
   parameter int unsigned MAX_RETRIES  = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [ADDR_W-1:0]                  req_dst,
   input  logic [$clog2(MAX_LEN+1)-1:0]       req_len,
   input  logic                               data_valid,
   output logic                               data_ready,
   input  logic [PAYLOAD_W-1:0]               data_in,
   output logic [FLIT_W-1:0]                  flit_o,
   output logic                               enable_o,
   input  logic                               ack_i,
   input  logic                               rej_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               abort_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retries_o,
   output logic                               proto_err_o
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned RTY_W = $clog2(MAX_RETRIES + 2);
   localparam int unsigned RTO_W = $clog2(MAX_RETRIES + 1);
   localparam int unsigned BO_W  = $clog2(BACKOFF_MAX + 2);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

   // Diagnostic coordinates must fit the address fields of this fabric.
   if (X >= (1 << COORD_W) || Y >= (1 << COORD_W)) begin : g_bad_xy
      $error("noc_injector: X/Y outside address range");
   end
   if (MAX_LEN < 1) begin : g_bad_len
      $error("noc_injector: MAX_LEN must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_REQ,
      S_SEND,
      S_GAP,
      S_BACKOFF
   } state_t;

   state_t                 state;
   logic [PAYLOAD_W-1:0]   pbuf [MAX_LEN];
   addr_t                  dst_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       wcnt;
   logic [LEN_W-1:0]       rcnt;
   logic [RTY_W-1:0]       retries;
   logic [RTY_W-1:0]       retries_n;
   logic [BO_W-1:0]        bo_cnt;

   assign retries_n  = retries + RTY_W'(1);
   assign req_ready  = (state == S_IDLE) && !rst;
   assign data_ready = (state == S_LOAD);

   // Backoff after the r-th reject: BACKOFF_BASE doubled (r-1) times, saturated.
   function automatic logic [BO_W-1:0] backoff_len(input logic [RTY_W-1:0] r);
      int unsigned v;
      v = BACKOFF_BASE;
      for (int unsigned i = 1; i < MAX_RETRIES; i++) begin
         if (i < 32'(r)) v = (v >= BACKOFF_MAX) ? BACKOFF_MAX : (v << 1);
      end
      if (v > BACKOFF_MAX) v = BACKOFF_MAX;
      return BO_W'(v);
   endfunction

   function automatic flit_t hdr_flit(input addr_t d);
      flit_hdr_t h;
      h          = '0;
      h.dst_addr = d;
      hdr_flit.flit_type = FLIT_HEADER;
      hdr_flit.payload   = h;
   endfunction

   function automatic flit_t data_flit(input logic last, input logic [PAYLOAD_W-1:0] w);
      data_flit.flit_type = last ? FLIT_TAIL : FLIT_BODY;
      data_flit.payload   = w;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         dst_q       <= '0;
         len_q       <= '0;
         wcnt        <= '0;
         rcnt        <= '0;
         retries     <= '0;
         bo_cnt      <= '0;
         flit_o      <= '0;
         enable_o    <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         abort_o     <= 1'b0;
         retries_o   <= '0;
         proto_err_o <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) pbuf[i] <= '0;
      end else begin
         done_o  <= 1'b0;
         abort_o <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  dst_q     <= addr_t'(req_dst);
                  len_q     <= (req_len == '0)     ? LEN_ONE :
                               (req_len > LEN_MAX) ? LEN_MAX : req_len;
                  wcnt      <= '0;
                  retries   <= '0;
                  retries_o <= '0;
                  busy_o    <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (data_valid) begin
                  pbuf[IDX_W'(wcnt)] <= data_in;
                  wcnt               <= wcnt + LEN_ONE;
                  if (wcnt == len_q - LEN_ONE) begin
                     enable_o <= 1'b1;
                     flit_o   <= hdr_flit(dst_q);
                     state    <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (rej_i) begin
                  retries   <= retries_n;
                  retries_o <= (retries_n > RTY_MAX) ? RTO_W'(MAX_RETRIES) : RTO_W'(retries_n);
                  enable_o  <= 1'b0;
                  flit_o    <= '0;
                  if (retries_n > RTY_MAX) begin
                     abort_o <= 1'b1;
                     busy_o  <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     bo_cnt <= backoff_len(retries_n);
                     state  <= S_BACKOFF;
                  end
               end else if (ack_i) begin
                  flit_o <= data_flit(len_q == LEN_ONE, pbuf[0]);
                  rcnt   <= LEN_ONE;
                  state  <= S_SEND;
               end
            end
            S_SEND: begin
               // rcnt is the index of the next flit; rcnt==1 means the first SEND cycle.
               if ((rcnt != LEN_ONE && !ack_i) || rej_i) proto_err_o <= 1'b1;
               if (rcnt == len_q) begin
                  enable_o <= 1'b0;
                  flit_o   <= '0;
                  done_o   <= 1'b1;
                  state    <= S_GAP;
               end else begin
                  flit_o <= data_flit(rcnt == len_q - LEN_ONE, pbuf[IDX_W'(rcnt)]);
                  rcnt   <= rcnt + LEN_ONE;
               end
            end
            S_GAP: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            S_BACKOFF: begin
               if (bo_cnt <= BO_W'(1)) begin
                  enable_o <= 1'b1;
                  flit_o   <= hdr_flit(dst_q);
                  state    <= S_REQ;
               end else begin
                  bo_cnt <= bo_cnt - BO_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_injector.sv
// Directed bench for noc_injector: delivery, backoff/retry, abort, short packets,
// protocol-error detection and asynchronous reset.
module tb_noc_injector;
   import noc_injector_pkg::*;

   localparam int unsigned LEN_W = 4;
   localparam int unsigned FW    = 18;
   // HEADER to dst (x=2,y=1): type 01, payload {dst=4'b1001, src=0, rsvd=0}
   localparam logic [FW-1:0] HDR = 18'h1_9000;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_dst;
   logic [LEN_W-1:0]  req_len;
   logic              data_valid;
   logic              data_ready;
   logic [15:0]       data_in;
   logic [FW-1:0]     flit_o;
   logic              enable_o;
   logic              ack_i;
   logic              rej_i;
   logic              busy_o;
   logic              done_o;
   logic              abort_o;
   logic [1:0]        retries_o;
   logic              proto_err_o;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   noc_injector #(
      .X(1), .Y(1), .MAX_LEN(8), .BACKOFF_BASE(2), .BACKOFF_MAX(16), .MAX_RETRIES(3)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_dst(req_dst), .req_len(req_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .flit_o(flit_o), .enable_o(enable_o), .ack_i(ack_i), .rej_i(rej_i),
      .busy_o(busy_o), .done_o(done_o), .abort_o(abort_o),
      .retries_o(retries_o), .proto_err_o(proto_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [15:0] p);
      return {t, p};
   endfunction

   task automatic expect_flit(input string tag, input logic [FW-1:0] exp);
      chk({tag, "_en"}, 32'(enable_o), 32'(exp != '0));
      chk(tag, 32'(flit_o), 32'(exp));
   endtask

   // Handshake a descriptor and stream its words; returns in the first REQ cycle.
   task automatic start_pkt(input int len, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
      req_valid = 1'b1;
      req_dst   = 4'b1001;
      req_len   = LEN_W'(len);
      step();
      req_valid = 1'b0;
      chk("load_ready", 32'(data_ready), 32'd1);
      chk("load_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < len; i++) begin
         data_valid = 1'b1;
         data_in    = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : w3;
         step();
      end
      data_valid = 1'b0;
      chk("req_dready", 32'(data_ready), 32'd0);
   endtask

   // From a REQ cycle with rej_i high: expect n low cycles then the HEADER again.
   task automatic backoff(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk($sformatf("bo%0d_en", n), 32'(enable_o), 32'd0);
      end
      step();
      expect_flit($sformatf("bo%0d_hdr", n), HDR);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_dst = '0; req_len = '0;
      data_valid = 1'b0; data_in = '0; ack_i = 1'b0; rej_i = 1'b0;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_data_ready", 32'(data_ready), 32'd0);
      expect_flit("rst_flit", '0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_retries", 32'(retries_o), 32'd0);
      chk("rst_proto", 32'(proto_err_o), 32'd0);
      step(); step();
      rst = 1'b0;
      step();
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // 1: len=3, ack on the second REQ cycle
      start_pkt(3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0);
      expect_flit("t1_hdr1", HDR);
      step();
      expect_flit("t1_hdr2", HDR);
      ack_i = 1'b1;
      step(); expect_flit("t1_a", mk(2'd2, 16'hAAAA));
      step(); expect_flit("t1_b", mk(2'd2, 16'hBBBB));
      step(); expect_flit("t1_c", mk(2'd3, 16'hCCCC));
      step();
      ack_i = 1'b0;
      expect_flit("t1_gap", '0);
      chk("t1_done", 32'(done_o), 32'd1);
      chk("t1_retries", 32'(retries_o), 32'd0);
      step();
      chk("t1_done_fall", 32'(done_o), 32'd0);
      chk("t1_busy", 32'(busy_o), 32'd0);
      chk("t1_proto", 32'(proto_err_o), 32'd0);

      // 2: one reject, 2-cycle backoff, then delivery
      start_pkt(3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0);
      rej_i = 1'b1;
      step();
      rej_i = 1'b0;
      chk("t2_bo1", 32'(enable_o), 32'd0);
      chk("t2_retries", 32'(retries_o), 32'd1);
      step();
      chk("t2_bo2", 32'(enable_o), 32'd0);
      step();
      expect_flit("t2_hdr", HDR);
      ack_i = 1'b1;
      step(); expect_flit("t2_a", mk(2'd2, 16'hAAAA));
      step(); expect_flit("t2_b", mk(2'd2, 16'hBBBB));
      step(); expect_flit("t2_c", mk(2'd3, 16'hCCCC));
      chk("t2_retries_send", 32'(retries_o), 32'd1);
      step();
      ack_i = 1'b0;
      chk("t2_done", 32'(done_o), 32'd1);
      step();

      // 3: reject every REQ: backoffs 2, 4, 8 then abort
      start_pkt(2, 16'h1234, 16'h5678, 16'h0, 16'h0);
      rej_i = 1'b1;
      backoff(2);
      chk("t3_r1", 32'(retries_o), 32'd1);
      backoff(4);
      chk("t3_r2", 32'(retries_o), 32'd2);
      backoff(8);
      chk("t3_r3", 32'(retries_o), 32'd3);
      step();
      rej_i = 1'b0;
      chk("t3_abort", 32'(abort_o), 32'd1);
      chk("t3_busy", 32'(busy_o), 32'd0);
      chk("t3_req_ready", 32'(req_ready), 32'd1);
      chk("t3_en", 32'(enable_o), 32'd0);
      step();
      chk("t3_abort_fall", 32'(abort_o), 32'd0);

      // 4: len=1, immediate ack: HEADER then TAIL only
      start_pkt(1, 16'hDDDD, 16'h0, 16'h0, 16'h0);
      expect_flit("t4_hdr", HDR);
      ack_i = 1'b1;
      step(); expect_flit("t4_tail", mk(2'd3, 16'hDDDD));
      step();
      ack_i = 1'b0;
      expect_flit("t4_gap", '0);
      chk("t4_done", 32'(done_o), 32'd1);
      step();
      chk("t4_busy", 32'(busy_o), 32'd0);
      chk("t4_proto", 32'(proto_err_o), 32'd0);

      // 5: ack dropped on second SEND cycle of len=4
      start_pkt(4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      ack_i = 1'b1;
      step(); expect_flit("t5_f0", mk(2'd2, 16'h1111));
      step(); expect_flit("t5_f1", mk(2'd2, 16'h2222));
      ack_i = 1'b0;
      chk("t5_proto_pre", 32'(proto_err_o), 32'd0);
      step(); expect_flit("t5_f2", mk(2'd2, 16'h3333));
      chk("t5_proto_set", 32'(proto_err_o), 32'd1);
      ack_i = 1'b1;
      step(); expect_flit("t5_f3", mk(2'd3, 16'h4444));
      step();
      ack_i = 1'b0;
      chk("t5_done", 32'(done_o), 32'd1);
      step();
      chk("t5_proto_sticky", 32'(proto_err_o), 32'd1);

      // 6: asynchronous reset in the middle of SEND
      start_pkt(4, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      ack_i = 1'b1;
      step(); step();
      expect_flit("t6_f1", mk(2'd2, 16'h2222));
      #2 rst = 1'b1;
      #1;
      chk("t6_async_en", 32'(enable_o), 32'd0);
      chk("t6_async_flit", 32'(flit_o), 32'd0);
      #1 rst = 1'b0;
      ack_i = 1'b0;
      step();
      chk("t6_req_ready", 32'(req_ready), 32'd1);
      chk("t6_retries", 32'(retries_o), 32'd0);
      chk("t6_busy", 32'(busy_o), 32'd0);
      chk("t6_proto", 32'(proto_err_o), 32'd0);
      expect_flit("t6_idle", '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
